cam_frame_ctrl: RTL and testbench
=================================

// Module: cam_frame_ctrl
// PURPOSE
//  Sequences frame capture from the camera write-FIFO path into a two-bank on-chip image buffer.
//  Raises cam_rd_ready to request one frame, then writes each valid 16-bit word with a raster address.
//  Hands the finished bank to the AI core and waits for the core to release it (ping-pong).
//  Sits in the r_clk domain, between the camera FIFO read side and the AI core feature-map buffer.
// PARAMETERS
//  H_WIDTH      112  words per line (one 16-bit word per pixel)
//  V_WIDTH      112  lines per frame
//  ADDR_W       14   buffer address width; must satisfy 2^ADDR_W >= H_WIDTH*V_WIDTH
//  TIMEOUT_W    24   width of the idle-beat watchdog counter
//  DRAIN_CYCLES 8    cycles cam_rd_ready is held low after a frame ends or is aborted
// PORTS
//  r_clk          in   1       system clock
//  RSTn           in   1       synchronous active-low reset
//  start          in   1       capture request pulse; latched as pending
//  abort          in   1       cancel current capture (level, sampled each cycle)
//  cam_rd_ready   out  1       frame request to the camera capture path
//  cam_data_valid in   1       camera FIFO word valid
//  cam_data       in   16      camera FIFO word
//  buf_we         out  1       buffer write enable
//  buf_bank       out  1       bank being written
//  buf_waddr      out  ADDR_W  raster address row*H_WIDTH+col
//  buf_wdata      out  16      write data
//  bank_full      out  2       bank holds a complete frame not yet released
//  bank_release   in   2       core frees bank(s); one bit per bank, pulse
//  frame_done     out  1       one-cycle pulse when a frame completes
//  frame_bank     out  1       bank of the last completed frame; valid with frame_done
//  busy           out  1       FSM not in IDLE
//  timeout_err    out  1       sticky watchdog flag; cleared by reset or an accepted start
// BEHAVIOUR
//  Reset (RSTn=0 at a r_clk edge): all outputs 0, FSM IDLE, pending/counters/bank_full cleared.
//   Applies mid-frame too: the partial frame is dropped and no bank is marked full.
//  FSM states:
//   IDLE:    leave when pending & a bank is free. Select bank 0 if free, else bank 1.
//            Clear col/row, the watchdog and timeout_err; go to ARM.
//   ARM:     cam_rd_ready=1. On the first cam_data_valid, go to CAPTURE; that word is written to addr 0.
//   CAPTURE: cam_rd_ready=1. Each valid word is written the same cycle and col increments.
//            At col==H_WIDTH-1, col wraps to 0 and row increments.
//            On the word at row==V_WIDTH-1 and col==H_WIDTH-1, go to DRAIN, set bank_full[bank],
//            and pulse frame_done with frame_bank.
//   DRAIN:   cam_rd_ready=0 for DRAIN_CYCLES, then IDLE. Any valid words are discarded (buf_we=0).
//  Write path is combinational: buf_we=cam_data_valid in ARM/CAPTURE, buf_wdata=cam_data, 0 latency.
//   cam_data_valid in IDLE or DRAIN is dropped silently.
//  pending: set by start. It is consumed on the IDLE->ARM transition. A start while busy stays pending.
//  abort in ARM/CAPTURE: go to DRAIN with no bank_full and no frame_done. abort in IDLE clears pending.
//  Watchdog: counts cycles in ARM/CAPTURE without cam_data_valid; any valid beat resets it to 0.
//   At all-ones: set timeout_err and go to DRAIN (same as abort).
//  bank_release[i] clears bank_full[i]. Releasing a bank that is not full is ignored.
//   If a set and a release of the same bank happen in the same cycle, the set wins.
//  Both banks full: remain in IDLE with pending held until a release.
//  abort, timeout and the final word in the same cycle: the final word completes the frame (done wins).
// TESTING
//  1 Nominal: reset, start, 12544 valid beats -> addr 0..12543 on bank 0, frame_done=1, frame_bank=0,
//    bank_full=2'b01, cam_rd_ready low 8 cycles.
//  2 Ping-pong: frame into bank 0 with no release, start again -> bank 1 used.
//    A third start waits in IDLE until bank_release=2'b01, then uses bank 0.
//  3 Raster wrap: beat 112 -> buf_waddr=112 (row 1, col 0). Gaps in valid -> no address skips.
//  4 Abort at beat 500 -> DRAIN, no frame_done, bank_full unchanged.
//    The next frame restarts at addr 0 in the same bank.
//  5 Watchdog (TIMEOUT_W=4): ARM with no data for 15 cycles -> timeout_err=1, DRAIN.
//    A later start clears timeout_err.
//  6 Reset at beat 6000, valid during DRAIN, and release+done in the same cycle
//    -> outputs 0 after reset / no buf_we / bank_full set.

Source files
------------

// File: rtl/cam_frame_ctrl.sv
// rtl/cam_frame_ctrl.sv - camera frame capture sequencer into a ping-pong image buffer
module cam_frame_ctrl #(
  parameter int H_WIDTH      = 112,
  parameter int V_WIDTH      = 112,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_W    = 24,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic              r_clk,
  input  logic              RSTn,
  input  logic              start,
  input  logic              abort,
  output logic              cam_rd_ready,
  input  logic              cam_data_valid,
  input  logic [15:0]       cam_data,
  output logic              buf_we,
  output logic              buf_bank,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [15:0]       buf_wdata,
  output logic [1:0]        bank_full,
  input  logic [1:0]        bank_release,
  output logic              frame_done,
  output logic              frame_bank,
  output logic              busy,
  output logic              timeout_err
);

  localparam int COL_W = (H_WIDTH > 1) ? $clog2(H_WIDTH) : 1;
  localparam int ROW_W = (V_WIDTH > 1) ? $clog2(V_WIDTH) : 1;
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  pending_q;
  logic                  bank_q;
  logic [1:0]            full_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [TIMEOUT_W-1:0]  wd_q;
  logic [DRN_W-1:0]      drn_q;
  logic                  done_q;
  logic                  fbank_q;
  logic                  terr_q;

  logic active, beat, last_col, last_row, final_beat, wd_expired, launch, drain_end;
  logic [1:0] set_mask;

  // Per-cycle qualifiers shared by the FSM and the datapath.
  always_comb begin
    active     = (state_q == ARM) || (state_q == CAPTURE);
    beat       = active && cam_data_valid;
    last_col   = (col_q == COL_W'(H_WIDTH - 1));
    last_row   = (row_q == ROW_W'(V_WIDTH - 1));
    final_beat = beat && last_col && last_row;
    wd_expired = (wd_q == '1);
    // An abort in IDLE cancels the request rather than racing it into ARM.
    launch     = (state_q == IDLE) && pending_q && (full_q != 2'b11) && !abort;
    drain_end  = (drn_q == DRN_W'(DRAIN_CYCLES - 1));
    set_mask   = final_beat ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
  end

  // State register.
  always_ff @(posedge r_clk) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the final word outranks abort and watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (launch) state_d = ARM;
      ARM, CAPTURE: begin
        if (final_beat || abort || wd_expired) state_d = DRAIN;
        else if (beat)                         state_d = CAPTURE;
      end
      DRAIN:         if (drain_end) state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  // Outputs; the write path is zero-latency and forced quiet outside ARM/CAPTURE.
  always_comb begin
    cam_rd_ready = active;
    buf_we       = beat;
    buf_wdata    = active ? cam_data : 16'h0000;
    buf_waddr    = active ? addr_q : '0;
    buf_bank     = bank_q;
    busy         = (state_q != IDLE);
    bank_full    = full_q;
    frame_done   = done_q;
    frame_bank   = fbank_q;
    timeout_err  = terr_q;
  end

  // Datapath: request latch, bank ownership, raster counters, watchdog and drain timer.
  always_ff @(posedge r_clk) begin
    if (!RSTn) begin
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      full_q    <= 2'b00;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
      drn_q     <= '0;
      done_q    <= 1'b0;
      fbank_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      pending_q <= start | (pending_q & ~launch & ~((state_q == IDLE) & abort));
      // A set in the same cycle as a release of that bank wins.
      full_q    <= (full_q & ~bank_release) | set_mask;
      done_q    <= final_beat;
      if (final_beat) fbank_q <= bank_q;

      if (launch) begin
        bank_q <= full_q[0];
        col_q  <= '0;
        row_q  <= '0;
        addr_q <= '0;
        wd_q   <= '0;
        terr_q <= 1'b0;
      end else if (active) begin
        if (beat) begin
          wd_q   <= '0;
          addr_q <= addr_q + ADDR_W'(1);
          if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end else begin
          wd_q <= wd_q + TIMEOUT_W'(1);
        end
        if (wd_expired && !final_beat) terr_q <= 1'b1;
      end

      if (state_q == DRAIN) drn_q <= drn_q + DRN_W'(1);
      else                  drn_q <= '0;
    end
  end

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// tb/tb_cam_frame_ctrl.sv - directed self-checking bench for cam_frame_ctrl
module tb_cam_frame_ctrl;

  localparam int H = 112;
  localparam int V = 112;
  localparam int AW = 14;
  localparam int NPIX = H * V;

  logic          r_clk = 1'b0;
  logic          RSTn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cam_rd_ready;
  logic          cam_data_valid = 1'b0;
  logic [15:0]   cam_data = 16'h0000;
  logic          buf_we;
  logic          buf_bank;
  logic [AW-1:0] buf_waddr;
  logic [15:0]   buf_wdata;
  logic [1:0]    bank_full;
  logic [1:0]    bank_release = 2'b00;
  logic          frame_done;
  logic          frame_bank;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  cam_frame_ctrl #(
    .H_WIDTH(H), .V_WIDTH(V), .ADDR_W(AW), .TIMEOUT_W(4), .DRAIN_CYCLES(8)
  ) dut (
    .r_clk(r_clk), .RSTn(RSTn), .start(start), .abort(abort),
    .cam_rd_ready(cam_rd_ready), .cam_data_valid(cam_data_valid), .cam_data(cam_data),
    .buf_we(buf_we), .buf_bank(buf_bank), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .bank_full(bank_full), .bank_release(bank_release), .frame_done(frame_done),
    .frame_bank(frame_bank), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_arm(input string tag);
    int n;
    n = 0;
    while (!cam_rd_ready && n < 30) begin
      tick();
      n++;
    end
    chk(tag, cam_rd_ready, 1);
  endtask

  function automatic logic [15:0] pix(input int idx);
    return 16'((idx * 7) ^ 16'h1234);
  endfunction

  // Drives n words starting at raster index first; checks every write beat.
  task automatic send_beats(input string tag, input int first, input int n,
                            input bit gaps, input logic exp_bank);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 7 == 3)) begin
        cam_data_valid = 1'b0;
        #1;
        if (buf_we !== 1'b0) bad++;
        tick();
      end
      cam_data_valid = 1'b1;
      cam_data = pix(first + i);
      #1;
      if (buf_we !== 1'b1 || buf_waddr !== AW'(first + i) ||
          buf_wdata !== pix(first + i) || buf_bank !== exp_bank) bad++;
      tick();
    end
    cam_data_valid = 1'b0;
    chk(tag, bad, 0);
  endtask

  // Measures the drain window while feeding words that must be discarded.
  task automatic drain_check(input string tag);
    int n;
    int rdy;
    int we;
    n = 0; rdy = 0; we = 0;
    cam_data_valid = 1'b1;
    cam_data = 16'hBEEF;
    #1;
    while (busy && n < 20) begin
      if (cam_rd_ready) rdy++;
      if (buf_we) we++;
      n++;
      tick();
    end
    cam_data_valid = 1'b0;
    chk({tag, "_len"}, n, 8);
    chk({tag, "_rdy"}, rdy, 0);
    chk({tag, "_we"}, we, 0);
  endtask

  initial begin
    int n;
    cam_data = 16'hFFFF;
    repeat (3) tick();
    chk("rst_rdy", cam_rd_ready, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_waddr", buf_waddr, 0);
    chk("rst_wdata", buf_wdata, 0);
    chk("rst_full", bank_full, 0);
    chk("rst_done", {frame_done, frame_bank, buf_bank}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    RSTn = 1'b1;
    tick();

    // Nominal frame into bank 0
    do_start();
    wait_arm("t1_arm");
    send_beats("t1_beats", 0, NPIX, 1'b0, 1'b0);
    chk("t1_done", frame_done, 1);
    chk("t1_fbank", frame_bank, 0);
    chk("t1_full", bank_full, 2'b01);
    drain_check("t1_drain");
    chk("t1_done_pulse", frame_done, 0);
    chk("t1_idle", busy, 0);

    // Releasing a bank that is not full changes nothing
    bank_release = 2'b10;
    tick();
    bank_release = 2'b00;
    chk("rel_ignored", bank_full, 2'b01);

    // Abort in IDLE cancels a pending request
    do_start();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    chk("idle_abort", busy, 0);

    // Second frame goes to bank 1, with gaps and the row-1 wrap
    do_start();
    wait_arm("t2_arm");
    send_beats("t2_beats_a", 0, 112, 1'b1, 1'b1);
    cam_data_valid = 1'b1;
    cam_data = pix(112);
    #1;
    chk("t3_wrap_addr", buf_waddr, 112);
    tick();
    send_beats("t2_beats_b", 113, NPIX - 113, 1'b1, 1'b1);
    chk("t2_done", frame_done, 1);
    chk("t2_fbank", frame_bank, 1);
    chk("t2_full", bank_full, 2'b11);
    drain_check("t2_drain");

    // Third request waits with both banks full
    do_start();
    repeat (20) tick();
    chk("t2_wait_busy", busy, 0);
    chk("t2_wait_rdy", cam_rd_ready, 0);
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    chk("t2_rel_full", bank_full, 2'b10);
    wait_arm("t2_arm3");
    chk("t2_bank3", buf_bank, 0);
    send_beats("t2_beats3", 0, NPIX - 1, 1'b0, 1'b0);
    cam_data_valid = 1'b1;
    cam_data = pix(NPIX - 1);
    bank_release = 2'b01;
    #1;
    chk("t6_last_addr", buf_waddr, NPIX - 1);
    tick();
    cam_data_valid = 1'b0;
    bank_release = 2'b00;
    chk("t6_set_wins", bank_full, 2'b11);
    chk("t2_done3", {frame_done, frame_bank}, 2'b10);
    drain_check("t2_drain3");

    // Abort mid-frame
    bank_release = 2'b11;
    tick();
    bank_release = 2'b00;
    chk("t4_rel_all", bank_full, 2'b00);
    do_start();
    wait_arm("t4_arm");
    send_beats("t4_beats", 0, 500, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_done", frame_done, 0);
    chk("t4_full", bank_full, 2'b00);
    chk("t4_terr", timeout_err, 0);
    drain_check("t4_drain");

    // Watchdog in ARM
    do_start();
    wait_arm("t5_arm");
    n = 0;
    while (cam_rd_ready && n < 40) begin
      n++;
      tick();
    end
    chk("t5_wd_cycles", n, 16);
    chk("t5_terr", timeout_err, 1);
    chk("t5_full", bank_full, 2'b00);
    drain_check("t5_drain");
    chk("t5_sticky", timeout_err, 1);
    do_start();
    wait_arm("t5_arm2");
    chk("t5_terr_clr", timeout_err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    drain_check("t5_drain2");

    // Restart in bank 0 at address 0, then reset mid-frame
    do_start();
    wait_arm("t4_rearm");
    chk("t4_rebank", buf_bank, 0);
    send_beats("t4_restart", 0, 6000, 1'b0, 1'b0);
    cam_data_valid = 1'b1;
    cam_data = pix(6000);
    RSTn = 1'b0;
    tick();
    chk("t6_rst_we", buf_we, 0);
    chk("t6_rst_rdy", cam_rd_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_full", bank_full, 0);
    chk("t6_rst_waddr", buf_waddr, 0);
    cam_data_valid = 1'b0;
    RSTn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
